// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART receive state machine and the
// receive datapath.
//   UART_FRAME_BITS : frame length in bit periods (start + 8 data + stop)
//   UART_DATA_W     : data byte width
//   UART_START_LVL  : required level of the start bit
//   UART_STOP_LVL   : required level of the stop bit
//   rx_entry_t      : receive FIFO entry, fe in bit 8, data in bits 7:0
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int   UART_FRAME_BITS = 10;
   localparam int   UART_DATA_W     = 8;
   localparam logic UART_START_LVL  = 1'b0;
   localparam logic UART_STOP_LVL   = 1'b1;

   typedef struct packed {
      logic                   fe;
      logic [UART_DATA_W-1:0] data;
   } rx_entry_t;

   localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage : uart_pkg

// File: rtl/rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
// Generic synchronous FIFO, first-word-fall-through head output.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail (ignored when full unless popping)
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry, zero while empty
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module rx_fifo #(
   parameter  int WIDTH = 9,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  logic [WIDTH-1:0] din,
   input  logic           pop,
   output logic [WIDTH-1:0] dout,
   output logic           full,
   output logic           empty,
   output logic [AW:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // The extra MSB on each pointer tells a full FIFO apart from an empty one.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

   // A push into a full FIFO is accepted only when a pop frees a slot in the
   // same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head is forced to zero when empty so the outputs have a defined value
   // without the storage array needing a reset.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its inputs, regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; only the pointers are, which
   // keeps the array as plain RAM and the empty gate on dout hides stale data.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule : rx_fifo

// File: rtl/rx_data_path.sv
// -----------------------------------------------------------------------------
// rx_data_path
// UART receive datapath: assembles the serial frame, checks start/stop/length
// on load, queues {fe, data} in a receive FIFO and flags overrun.
//   rxd_clk, rxd_rst_n : bit clock, asynchronous active-low reset
//   rx_in              : synchronised serial line
//   shift              : sample rx_in into the frame register
//   load               : frame complete, check and push (wins over shift)
//   rxd_data, rxd_fe   : head entry of the receive FIFO
//   rxd_valid          : FIFO non-empty
//   rxd_ready          : consumer accepts head entry
//   rxd_overrun        : sticky, frame dropped on a full FIFO
//   rxd_clr_err        : clears rxd_overrun (a same-cycle set wins)
//   rxd_level          : FIFO occupancy
// -----------------------------------------------------------------------------
module rx_data_path
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int FRAME_BITS = UART_FRAME_BITS
) (
   input  logic                         rxd_clk,
   input  logic                         rxd_rst_n,
   input  logic                         rx_in,
   input  logic                         shift,
   input  logic                         load,
   output logic [UART_DATA_W-1:0]       rxd_data,
   output logic                         rxd_fe,
   output logic                         rxd_valid,
   input  logic                         rxd_ready,
   output logic                         rxd_overrun,
   input  logic                         rxd_clr_err,
   output logic [$clog2(FIFO_DEPTH):0]  rxd_level
);

   logic [FRAME_BITS-1:0] frm;
   logic [3:0]            cnt;
   rx_entry_t             push_entry;
   rx_entry_t             head_entry;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;

   // Frame register shifts right so the first bit received (start) ends in
   // frm[0]. The counter saturates so an over-long frame can never wrap back
   // to a legal count.
   always_ff @(posedge rxd_clk or negedge rxd_rst_n) begin
      if (!rxd_rst_n) begin
         frm <= '1;
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (shift) begin
         frm <= {rx_in, frm[FRAME_BITS-1:1]};
         if (cnt != 4'hF) cnt <= cnt + 4'd1;
      end
   end

   // NOTE: every signal written in always_comb gets a default first so no
   // path leaves it unassigned and a latch cannot be inferred.
   always_comb begin
      push_entry      = '0;
      push_entry.data = frm[UART_DATA_W:1];
      push_entry.fe   = (frm[0] != UART_START_LVL) ||
                        (frm[FRAME_BITS-1] != UART_STOP_LVL) ||
                        (cnt != 4'(FRAME_BITS));
   end

   assign fifo_pop = rxd_ready && !fifo_empty;

   rx_fifo #(
      .WIDTH (RX_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (rxd_clk),
      .rst_n (rxd_rst_n),
      .push  (load),
      .din   (push_entry),
      .pop   (fifo_pop),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (rxd_level)
   );

   assign rxd_data  = head_entry.data;
   assign rxd_fe    = head_entry.fe;
   assign rxd_valid = !fifo_empty;

   // A frame is dropped only when the FIFO is full and nothing leaves in the
   // same cycle; the set takes priority over a simultaneous clear.
   always_ff @(posedge rxd_clk or negedge rxd_rst_n) begin
      if (!rxd_rst_n) begin
         rxd_overrun <= 1'b0;
      end else if (load && fifo_full && !fifo_pop) begin
         rxd_overrun <= 1'b1;
      end else if (rxd_clr_err) begin
         rxd_overrun <= 1'b0;
      end
   end

endmodule : rx_data_path

// File: tb/tb_rx_data_path.sv
// -----------------------------------------------------------------------------
// tb_rx_data_path
// Directed bench for rx_data_path: good frames, bad start/stop, wrong length,
// overrun, full FIFO with simultaneous pop, load/shift collision, clear/set
// collision, asynchronous reset mid-frame.
// -----------------------------------------------------------------------------
module tb_rx_data_path;

   logic       rxd_clk;
   logic       rxd_rst_n;
   logic       rx_in;
   logic       shift;
   logic       load;
   logic [7:0] rxd_data;
   logic       rxd_fe;
   logic       rxd_valid;
   logic       rxd_ready;
   logic       rxd_overrun;
   logic       rxd_clr_err;
   logic [2:0] rxd_level;

   int n_total = 0;
   int n_bad   = 0;

   rx_data_path #(.FIFO_DEPTH(4)) dut (
      .rxd_clk     (rxd_clk),
      .rxd_rst_n   (rxd_rst_n),
      .rx_in       (rx_in),
      .shift       (shift),
      .load        (load),
      .rxd_data    (rxd_data),
      .rxd_fe      (rxd_fe),
      .rxd_valid   (rxd_valid),
      .rxd_ready   (rxd_ready),
      .rxd_overrun (rxd_overrun),
      .rxd_clr_err (rxd_clr_err),
      .rxd_level   (rxd_level)
   );

   initial rxd_clk = 1'b0;
   always #5 rxd_clk = ~rxd_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge rxd_clk);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      rx_in = b;
      shift = 1'b1;
      tick();
      shift = 1'b0;
      rx_in = 1'b1;
   endtask

   // Shift a frame: start, data LSB first, stop.
   // extra = -1 stops after 9 shifts, +1 prepends an idle bit for 11 shifts.
   task automatic shift_frame(input logic [7:0] d, input logic st, input logic sp, input int extra);
      logic [9:0] bits;
      int         n;
      bits = {sp, d, st};
      n    = (extra < 0) ? 9 : 10;
      if (extra > 0) shift_bit(1'b1);
      for (int i = 0; i < n; i++) shift_bit(bits[i]);
   endtask

   task automatic do_load();
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic st, input logic sp, input int extra);
      shift_frame(d, st, sp, extra);
      do_load();
   endtask

   task automatic pop();
      rxd_ready = 1'b1;
      tick();
      rxd_ready = 1'b0;
   endtask

   initial begin
      rxd_rst_n   = 1'b0;
      rx_in       = 1'b1;
      shift       = 1'b0;
      load        = 1'b0;
      rxd_ready   = 1'b0;
      rxd_clr_err = 1'b0;
      #23;
      check("rst_valid",   rxd_valid,   0);
      check("rst_overrun", rxd_overrun, 0);
      check("rst_level",   rxd_level,   0);
      check("rst_data",    rxd_data,    8'h00);
      check("rst_fe",      rxd_fe,      0);
      rxd_rst_n = 1'b1;
      tick();

      // Good frame 0xA5
      send(8'hA5, 1'b0, 1'b1, 0);
      check("a5_valid", rxd_valid, 1);
      check("a5_data",  rxd_data,  8'hA5);
      check("a5_fe",    rxd_fe,    0);
      check("a5_level", rxd_level, 1);
      pop();
      check("a5_pop_valid", rxd_valid, 0);
      check("a5_pop_level", rxd_level, 0);

      // Bad stop bit
      send(8'h3C, 1'b0, 1'b0, 0);
      check("badstop_data", rxd_data, 8'h3C);
      check("badstop_fe",   rxd_fe,   1);
      pop();

      // Bad start bit
      send(8'h00, 1'b1, 1'b1, 0);
      check("badstart_data", rxd_data, 8'h00);
      check("badstart_fe",   rxd_fe,   1);
      pop();

      // Short and long frames
      send(8'h55, 1'b0, 1'b1, -1);
      check("short_fe", rxd_fe, 1);
      pop();
      send(8'h55, 1'b0, 1'b1, 1);
      check("long_data", rxd_data, 8'h55);
      check("long_fe",   rxd_fe,   1);
      pop();
      check("len_empty", rxd_valid, 0);

      // Overrun: five frames into a four-entry FIFO
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b1, 0);
      check("ovr_level", rxd_level,   4);
      check("ovr_flag",  rxd_overrun, 1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("ovr_drain%0d", i), rxd_data, 32'(i));
         pop();
      end
      check("ovr_drained", rxd_valid, 0);
      check("ovr_hold",    rxd_overrun, 1);
      rxd_clr_err = 1'b1;
      tick();
      rxd_clr_err = 1'b0;
      check("ovr_clr", rxd_overrun, 0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b0, 1'b1, 0);
      check("pp_full_level", rxd_level, 4);
      shift_frame(8'h14, 1'b0, 1'b1, 0);
      rxd_ready = 1'b1;
      do_load();
      rxd_ready = 1'b0;
      check("pp_overrun", rxd_overrun, 0);
      check("pp_level",   rxd_level,   4);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("pp_drain%0d", i), rxd_data, 32'h10 + 32'(i));
         pop();
      end

      // Overrun set and clear in the same cycle: set wins
      for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b0, 1'b1, 0);
      shift_frame(8'h24, 1'b0, 1'b1, 0);
      rxd_clr_err = 1'b1;
      do_load();
      rxd_clr_err = 1'b0;
      check("setwin_overrun", rxd_overrun, 1);
      check("setwin_level",   rxd_level,   4);
      check("setwin_head",    rxd_data,    8'h20);
      rxd_clr_err = 1'b1;
      tick();
      rxd_clr_err = 1'b0;
      for (int i = 0; i < 4; i++) pop();
      check("setwin_empty", rxd_level, 0);

      // Load and shift together: shift ignored, next frame length still 10
      shift_frame(8'h66, 1'b0, 1'b1, 0);
      rx_in = 1'b0;
      shift = 1'b1;
      do_load();
      shift = 1'b0;
      rx_in = 1'b1;
      send(8'h99, 1'b0, 1'b1, 0);
      check("ls_level",   rxd_level, 2);
      check("ls_data0",   rxd_data,  8'h66);
      check("ls_fe0",     rxd_fe,    0);
      pop();
      check("ls_data1",   rxd_data,  8'h99);
      check("ls_fe1",     rxd_fe,    0);
      pop();

      // Asynchronous reset mid-frame
      send(8'h77, 1'b0, 1'b1, 0);
      check("mid_pre_valid", rxd_valid, 1);
      for (int i = 0; i < 5; i++) shift_bit(1'b0);
      #2;
      rxd_rst_n = 1'b0;
      #1;
      check("mid_valid", rxd_valid, 0);
      check("mid_level", rxd_level, 0);
      check("mid_data",  rxd_data,  8'h00);
      check("mid_fe",    rxd_fe,    0);
      #2;
      rxd_rst_n = 1'b1;
      tick();
      send(8'h5A, 1'b0, 1'b1, 0);
      check("post_valid", rxd_valid, 1);
      check("post_data",  rxd_data,  8'h5A);
      check("post_fe",    rxd_fe,    0);
      check("post_level", rxd_level, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_rx_data_path
